// File: rtl/mem_io_bridge_if.sv
// CPU-side memory bus between the CPU core and mem_io_bridge.
// The CPU drives commands through the master modport; the bridge answers through the slave modport.
interface mem_io_bridge_if;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] write_data;
   logic [15:0] read_data;
   logic        rd_valid;

   modport master (
      output mem_cmd,
      output mem_addr,
      output write_data,
      input  read_data,
      input  rd_valid
   );

   modport slave (
      input  mem_cmd,
      input  mem_addr,
      input  write_data,
      output read_data,
      output rd_valid
   );
endinterface

// File: rtl/mem_io_bridge.sv
// Memory-bus decode stage: routes CPU accesses to the 256x16 RAM or to on-board I/O (LEDs, switches, timer).
// Defining IO_TIMER_EN builds the prescaled tick timer at 0x180; without it that address is unmapped.
module mem_io_bridge #(
   parameter int PRESCALE   = 50000,
   parameter int PRESCALE_W = 16,
   parameter int RAM_AW     = 8
) (
   input  logic              clk,
   input  logic              reset,
   mem_io_bridge_if.slave    bus,
   output logic              ram_write,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [15:0]       ram_din,
   input  logic [15:0]       ram_dout,
   input  logic [9:0]        sw,
   output logic [7:0]        ledr,
   output logic              bad_access
);

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_LED,
      SEL_SWV,
      SEL_SWE,
      SEL_TMR,
      SEL_NONE
   } sel_t;

   sel_t        sel;
   sel_t        sel_q;
   logic        is_read;
   logic        is_write;
   logic        rd_pend;
   logic [15:0] io_value;
   logic [15:0] io_q;
   logic [15:0] rd_mux;
   logic [15:0] read_hold;
   logic [9:0]  sw_meta;
   logic [9:0]  sw_sync;
   logic [7:0]  sw_prev;
   logic [7:0]  sw_rise;
   logic [7:0]  edge_flags;
   logic [7:0]  edge_clr;

`ifdef IO_TIMER_EN
   localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE - 1);
   logic [PRESCALE_W-1:0] presc;
   logic [15:0]           count;
`else
   logic unused_timer_cfg;
   assign unused_timer_cfg = ^{32'(PRESCALE), 32'(PRESCALE_W)};
`endif

   // Command 11 falls through both tests and behaves as no access.
   assign is_read  = (bus.mem_cmd == 2'b10);
   assign is_write = (bus.mem_cmd == 2'b01);

   assign ram_write = is_write & ~bus.mem_addr[8];
   assign ram_addr  = bus.mem_addr[RAM_AW-1:0];
   assign ram_din   = bus.write_data;

   always_comb begin
      sel = SEL_NONE;
      if (!bus.mem_addr[8]) begin
         sel = SEL_RAM;
      end else begin
         case (bus.mem_addr[7:0])
            8'h00:   sel = SEL_LED;
            8'h40:   sel = SEL_SWV;
            8'h41:   sel = SEL_SWE;
`ifdef IO_TIMER_EN
            8'h80:   sel = SEL_TMR;
`endif
            default: sel = SEL_NONE;
         endcase
      end
   end

   // I/O read value as seen in the request cycle; unmapped addresses read as zero.
   always_comb begin
      io_value = 16'h0000;
      case (sel)
         SEL_LED: io_value = {8'h00, ledr};
         SEL_SWV: io_value = {6'b000000, sw_sync};
         SEL_SWE: io_value = {8'h00, edge_flags};
`ifdef IO_TIMER_EN
         SEL_TMR: io_value = count;
`endif
         default: io_value = 16'h0000;
      endcase
   end

   // RAM data only becomes valid the cycle after the request, so it bypasses io_q.
   assign rd_mux        = (sel_q == SEL_RAM) ? ram_dout : io_q;
   assign bus.read_data = rd_pend ? rd_mux : read_hold;
   assign bus.rd_valid  = rd_pend;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_pend   <= 1'b0;
         sel_q     <= SEL_NONE;
         io_q      <= 16'h0000;
         read_hold <= 16'h0000;
      end else begin
         rd_pend <= is_read;
         if (is_read) begin
            sel_q <= sel;
            io_q  <= io_value;
         end
         if (rd_pend) begin
            read_hold <= rd_mux;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ledr       <= 8'h00;
         bad_access <= 1'b0;
      end else begin
         if (is_write && (sel == SEL_LED)) begin
            ledr <= bus.write_data[7:0];
         end
         if ((is_read || is_write) && (sel == SEL_NONE)) begin
            bad_access <= 1'b1;
         end
      end
   end

   // A read of SW_EDGE clears every flag; a write clears only the bits written as 1.
   assign sw_rise  = sw_sync[7:0] & ~sw_prev;
   assign edge_clr = (sel != SEL_SWE) ? 8'h00 :
                     is_read          ? 8'hFF :
                     is_write         ? bus.write_data[7:0] : 8'h00;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_meta    <= 10'h000;
         sw_sync    <= 10'h000;
         sw_prev    <= 8'h00;
         edge_flags <= 8'h00;
      end else begin
         sw_meta    <= sw;
         sw_sync    <= sw_meta;
         sw_prev    <= sw_sync[7:0];
         edge_flags <= (edge_flags & ~edge_clr) | sw_rise;
      end
   end

`ifdef IO_TIMER_EN
   // A CPU load restarts the prescaler so the next tick is a full period away.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
         count <= 16'h0000;
      end else if (is_write && (sel == SEL_TMR)) begin
         presc <= '0;
         count <= bus.write_data;
      end else if (presc == PRESC_LAST) begin
         presc <= '0;
         count <= count + 16'd1;
      end else begin
         presc <= presc + PRESCALE_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: reads are scoreboarded with their expected data and due cycle.
// Timer checks run only when IO_TIMER_EN is defined; otherwise 0x180 is checked as unmapped.
module tb_mem_io_bridge;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MWRITE = 2'b01;
   localparam logic [1:0] MREAD  = 2'b10;

   typedef struct {
      string       tag;
      logic [15:0] data;
      int          due;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        ram_write;
   logic [7:0]  ram_addr;
   logic [15:0] ram_din;
   logic [15:0] ram_dout;
   logic [9:0]  sw;
   logic [7:0]  ledr;
   logic        bad_access;
   logic [15:0] ram_mem [256];
   int          cyc;
   int          pass_cnt;
   int          fail_cnt;
   int          total_cnt;
   exp_t        exp_q [$];
   exp_t        got;

   mem_io_bridge_if bus ();

   mem_io_bridge #(
      .PRESCALE   (4),
      .PRESCALE_W (4),
      .RAM_AW     (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .ram_write  (ram_write),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_dout   (ram_dout),
      .sw         (sw),
      .ledr       (ledr),
      .bad_access (bad_access)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (ram_write) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] cmd, input logic [8:0] addr,
                                 input logic [15:0] wd, input logic [15:0] exp, input string tag);
      bus.mem_cmd    = cmd;
      bus.mem_addr   = addr;
      bus.write_data = wd;
      if (cmd == MREAD) exp_q.push_back('{tag, exp, cyc + 1});
      #1;
      check_output({tag, "/ram_write"}, 16'(ram_write), 16'((cmd == MWRITE) && !addr[8]));
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(MNONE, 9'h000, 16'h0000, 16'h0000, "idle");
   endtask

   // Every returned read must match the oldest outstanding request and arrive one cycle after it.
   always @(negedge clk) begin
      if (bus.rd_valid === 1'b1) begin
         check_output("rd_valid_expected", 16'(exp_q.size() != 0), 16'd1);
         if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            check_output(got.tag, bus.read_data, got.data);
            check_output({got.tag, "/latency"}, 16'(cyc), 16'(got.due));
         end
      end
   end

   initial begin
      cyc            = 0;
      pass_cnt       = 0;
      fail_cnt       = 0;
      total_cnt      = 0;
      reset          = 1'b0;
      sw             = 10'h000;
      bus.mem_cmd    = MNONE;
      bus.mem_addr   = 9'h000;
      bus.write_data = 16'h0000;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check_output("rst_rd_valid", 16'(bus.rd_valid), 16'd0);
      check_output("rst_read_data", bus.read_data, 16'h0000);
      check_output("rst_ledr", 16'(ledr), 16'h0000);
      check_output("rst_bad", 16'(bad_access), 16'd0);
      @(negedge clk);

      $display("[TB] RAM write and read");
      apply_stimulus(MWRITE, 9'h005, 16'hBEEF, 16'h0000, "ram_wr");
      check_output("ram_addr", 16'(ram_addr), 16'h0005);
      check_output("ram_din", ram_din, 16'hBEEF);
      apply_stimulus(MREAD, 9'h005, 16'h0000, 16'hBEEF, "ram_rd");
      apply_stimulus(MWRITE, 9'h010, 16'h1234, 16'h0000, "ram_wr2");

      $display("[TB] LED register");
      apply_stimulus(MWRITE, 9'h100, 16'h12A5, 16'h0000, "led_wr");
      check_output("ledr", 16'(ledr), 16'h00A5);
      apply_stimulus(MREAD, 9'h100, 16'h0000, 16'h00A5, "led_rd");
      idle(1);
      check_output("hold_valid", 16'(bus.rd_valid), 16'd0);
      check_output("hold_data", bus.read_data, 16'h00A5);
      apply_stimulus(2'b11, 9'h005, 16'hDEAD, 16'h0000, "cmd11");

      $display("[TB] switches and edge capture");
      sw = 10'h003;
      apply_stimulus(MREAD, 9'h140, 16'h0000, 16'h0000, "swv_d0");
      apply_stimulus(MREAD, 9'h140, 16'h0000, 16'h0000, "swv_d1");
      apply_stimulus(MREAD, 9'h140, 16'h0000, 16'h0003, "swv_d2");
      apply_stimulus(MREAD, 9'h141, 16'h0000, 16'h0003, "swe_rd1");
      apply_stimulus(MREAD, 9'h141, 16'h0000, 16'h0000, "swe_rd2");
      sw = 10'h002;
      idle(3);
      sw = 10'h003;
      idle(2);
      apply_stimulus(MWRITE, 9'h141, 16'h0001, 16'h0000, "swe_w1c_race");
      apply_stimulus(MREAD, 9'h141, 16'h0000, 16'h0001, "swe_edge_wins");
      apply_stimulus(MREAD, 9'h141, 16'h0000, 16'h0000, "swe_cleared");
      sw = 10'h007;
      idle(3);
      apply_stimulus(MWRITE, 9'h141, 16'h0004, 16'h0000, "swe_w1c");
      apply_stimulus(MREAD, 9'h141, 16'h0000, 16'h0000, "swe_after_w1c");

`ifdef IO_TIMER_EN
      $display("[TB] timer load and wrap");
      apply_stimulus(MWRITE, 9'h180, 16'hFFFE, 16'h0000, "tmr_load");
      idle(3);
      apply_stimulus(MREAD, 9'h180, 16'h0000, 16'hFFFE, "tmr_pre_tick");
      apply_stimulus(MREAD, 9'h180, 16'h0000, 16'hFFFF, "tmr_tick1");
      idle(3);
      apply_stimulus(MREAD, 9'h180, 16'h0000, 16'h0000, "tmr_wrap");
      check_output("tmr_bad", 16'(bad_access), 16'd0);
`else
      $display("[TB] timer address unmapped");
      check_output("pre_tmr_bad", 16'(bad_access), 16'd0);
      apply_stimulus(MREAD, 9'h180, 16'h0000, 16'h0000, "tmr_unmapped");
      check_output("tmr_bad", 16'(bad_access), 16'd1);
`endif

      $display("[TB] back-to-back reads");
      apply_stimulus(MREAD, 9'h010, 16'h0000, 16'h1234, "b2b_ram");
      apply_stimulus(MREAD, 9'h100, 16'h0000, 16'h00A5, "b2b_led");
      apply_stimulus(MREAD, 9'h140, 16'h0000, 16'h0007, "b2b_swv");
      idle(2);

      $display("[TB] unmapped access");
      apply_stimulus(MREAD, 9'h1F0, 16'h0000, 16'h0000, "unmapped_rd");
      check_output("bad_set", 16'(bad_access), 16'd1);
      apply_stimulus(MREAD, 9'h005, 16'h0000, 16'hBEEF, "ram_rd_after_bad");
      idle(1);
      check_output("bad_sticky", 16'(bad_access), 16'd1);

      $display("[TB] reset during read");
      bus.mem_cmd  = MREAD;
      bus.mem_addr = 9'h100;
      @(posedge clk);
      #1;
      check_output("mid_rd_valid", 16'(bus.rd_valid), 16'd1);
      #1;
      reset       = 1'b0;
      bus.mem_cmd = MNONE;
      #1;
      check_output("rst_mid_valid", 16'(bus.rd_valid), 16'd0);
      check_output("rst_mid_data", bus.read_data, 16'h0000);
      check_output("rst_mid_ledr", 16'(ledr), 16'h0000);
      check_output("rst_mid_bad", 16'(bad_access), 16'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      apply_stimulus(MWRITE, 9'h1FF, 16'h00FF, 16'h0000, "unmapped_wr");
      check_output("bad_on_write", 16'(bad_access), 16'd1);
      check_output("ledr_untouched", 16'(ledr), 16'h0000);

      idle(3);
      check_output("scoreboard_empty", 16'(exp_q.size()), 16'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
